// File: rtl/fpu_format_pkg.sv
// Shared types and constants for the FP add/sub formatting stage.
// Holds the controller state encoding, exponent limit helpers and format parameter sets.
package fpu_format_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    FORMAT = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Largest biased exponent that still encodes a finite value (all ones minus one, no carry).
  function automatic int unsigned u_limit(input int unsigned ew);
    return (32'd1 << (ew - 1)) - 32'd2;
  endfunction

  function automatic int unsigned l_limit(input int unsigned ew);
    return (ew > 0) ? 32'd1 : 32'd0;
  endfunction

  localparam int SP_EW = 9;
  localparam int SP_SW = 23;
  localparam int SP_W  = 1 + (SP_EW - 1) + SP_SW;

  localparam int DP_EW = 12;
  localparam int DP_SW = 52;
  localparam int DP_W  = 1 + (DP_EW - 1) + DP_SW;

endpackage

// File: rtl/fpu_format_ctrl_exp_range_check.sv
// Combinational exponent classifier: flags values above the finite range or below the normal range.
// The carry bit (MSB) participates, so any carry-out lands in overflow.
module exp_range_check
  import fpu_format_pkg::*;
#(
  parameter int EW = 9
) (
  input  logic [EW-1:0] exp,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [EW-1:0] U_LIM = EW'(u_limit(EW));
  localparam logic [EW-1:0] L_LIM = EW'(l_limit(EW));

  assign overflow  = (exp > U_LIM);
  assign underflow = (exp < L_LIM);

endmodule

// File: rtl/fpu_format_ctrl.sv
// Final formatting sequencer for the FP add/sub unit: captures normalized fields,
// classifies the exponent, packs the IEEE-754 word and hands it over with ready/ack.
module fpu_format_ctrl
  import fpu_format_pkg::*;
#(
  parameter int EW = 9,
  parameter int SW = 23,
  parameter int W  = 1 + (EW - 1) + SW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          beg_fsm,
  input  logic          ack_fsm,
  input  logic          sign_i,
  input  logic [EW-1:0] exp_i,
  input  logic [SW-1:0] sgf_i,
  input  logic          zero_flag_i,
  output logic          busy,
  output logic          ready,
  output logic [W-1:0]  final_result,
  output logic          overflow_flag,
  output logic          underflow_flag
);

  state_t        state_reg, state_next;
  logic          sign_reg;
  logic [EW-1:0] exp_reg;
  logic [SW-1:0] sgf_reg;
  logic          zero_reg;
  logic          overflow_flag_reg, underflow_flag_reg;
  logic [W-1:0]  result_reg, result_next;
  logic          busy_reg, ready_reg;
  logic          ovf_comb, unf_comb;

  exp_range_check #(.EW(EW)) u_range (
    .exp       (exp_reg),
    .overflow  (ovf_comb),
    .underflow (unf_comb)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (beg_fsm) state_next = CHECK;
      CHECK:   state_next = FORMAT;
      FORMAT:  state_next = DONE;
      DONE:    if (ack_fsm) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Exact zero outranks the exponent class; overflow keeps the sign and forces infinity.
  always_comb begin
    result_next        = '0;
    result_next[W-1]   = sign_reg;
    if (!zero_reg) begin
      if (overflow_flag_reg) begin
        result_next[W-2 -: (EW-1)] = {(EW-1){1'b1}};
      end else if (!underflow_flag_reg) begin
        result_next = {sign_reg, exp_reg[EW-2:0], sgf_reg};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      sign_reg           <= 1'b0;
      exp_reg            <= '0;
      sgf_reg            <= '0;
      zero_reg           <= 1'b0;
      overflow_flag_reg  <= 1'b0;
      underflow_flag_reg <= 1'b0;
      result_reg         <= '0;
      busy_reg           <= 1'b0;
      ready_reg          <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      ready_reg <= (state_next == DONE);
      if (state_reg == IDLE && beg_fsm) begin
        sign_reg <= sign_i;
        exp_reg  <= exp_i;
        sgf_reg  <= sgf_i;
        zero_reg <= zero_flag_i;
      end
      if (state_reg == CHECK) begin
        overflow_flag_reg  <= !zero_reg && ovf_comb;
        underflow_flag_reg <= !zero_reg && !ovf_comb && unf_comb;
      end
      if (state_reg == FORMAT) begin
        result_reg <= result_next;
      end
    end
  end

  assign busy           = busy_reg;
  assign ready          = ready_reg;
  assign final_result   = result_reg;
  assign overflow_flag  = overflow_flag_reg;
  assign underflow_flag = underflow_flag_reg;

endmodule

// File: tb/tb_fpu_format_ctrl.sv
// Self-checking bench: single and double builds share control, each checked against an arithmetic model.
module tb_fpu_format_ctrl;

  logic        clk = 1'b0;
  logic        rst, beg_fsm, ack_fsm, sign_i, zero_flag_i;
  logic [8:0]  s_exp;
  logic [22:0] s_sgf;
  logic [11:0] d_exp;
  logic [51:0] d_sgf;

  logic        s_busy, s_ready, s_ovf, s_unf;
  logic [31:0] s_res;
  logic        d_busy, d_ready, d_ovf, d_unf;
  logic [63:0] d_res;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_format_ctrl #(.EW(9), .SW(23), .W(32)) dut_s (
    .clk(clk), .rst(rst), .beg_fsm(beg_fsm), .ack_fsm(ack_fsm),
    .sign_i(sign_i), .exp_i(s_exp), .sgf_i(s_sgf), .zero_flag_i(zero_flag_i),
    .busy(s_busy), .ready(s_ready), .final_result(s_res),
    .overflow_flag(s_ovf), .underflow_flag(s_unf)
  );

  fpu_format_ctrl #(.EW(12), .SW(52), .W(64)) dut_d (
    .clk(clk), .rst(rst), .beg_fsm(beg_fsm), .ack_fsm(ack_fsm),
    .sign_i(sign_i), .exp_i(d_exp), .sgf_i(d_sgf), .zero_flag_i(zero_flag_i),
    .busy(d_busy), .ready(d_ready), .final_result(d_res),
    .overflow_flag(d_ovf), .underflow_flag(d_unf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: IEEE packing from field values with plain integer arithmetic.
  function automatic void model(input int ew, input int sw, input bit s, input longint unsigned e,
                                input longint unsigned sg, input bit z,
                                output longint unsigned res, output bit ovf, output bit unf);
    longint unsigned emax = (64'd1 << (ew - 1)) - 1;
    res = longint'(s) << (ew - 1 + sw);
    ovf = 0;
    unf = 0;
    if (!z) begin
      if (e > emax - 1) begin
        ovf = 1;
        res += emax << sw;
      end else if (e < 1) begin
        unf = 1;
      end else begin
        res += ((e % (emax + 1)) << sw) + sg;
      end
    end
  endfunction

  function automatic longint unsigned pick_exp(input int ew);
    longint unsigned lim = (64'd1 << (ew - 1)) - 2;
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return lim;
      3: return lim + 1;
      4: return lim + 1 + $urandom_range(0, 255);
      default: return $urandom_range(2, 200);
    endcase
  endfunction

  task automatic scramble();
    sign_i      = 1'($urandom);
    zero_flag_i = 1'($urandom);
    s_exp       = 9'($urandom);
    s_sgf       = 23'($urandom);
    d_exp       = 12'($urandom);
    d_sgf       = {20'($urandom), 32'($urandom)};
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_s_busy"}, 64'(s_busy), 64'd0);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_d_busy"}, 64'(d_busy), 64'd0);
    chk({tag, "_d_ready"}, 64'(d_ready), 64'd0);
  endtask

  // mode 0: plain; 1: beg re-pulsed in CHECK with new data; 2: beg together with ack in DONE.
  task automatic op(input string tag, input bit sg, input bit z, input logic [8:0] se,
                    input logic [22:0] ss, input logic [11:0] de, input logic [51:0] ds,
                    input int hold, input int mode);
    longint unsigned rs, rd;
    bit os, us, od, ud;
    model(9, 23, sg, 64'(se), 64'(ss), z, rs, os, us);
    model(12, 52, sg, 64'(de), 64'(ds), z, rd, od, ud);
    @(posedge clk); #1;
    sign_i = sg; zero_flag_i = z; s_exp = se; s_sgf = ss; d_exp = de; d_sgf = ds;
    beg_fsm = 1'b1;
    @(posedge clk); #1;
    beg_fsm = (mode == 1);
    scramble();
    chk({tag, "_busy"}, 64'({s_busy, d_busy, s_ready, d_ready}), 64'b1100);
    @(posedge clk); #1;
    beg_fsm = 1'b0;
    chk({tag, "_s_flags"}, 64'({s_ovf, s_unf}), 64'({os, us}));
    chk({tag, "_d_flags"}, 64'({d_ovf, d_unf}), 64'({od, ud}));
    @(posedge clk); #1;
    chk({tag, "_ready"}, 64'({s_busy, d_busy, s_ready, d_ready}), 64'b1111);
    chk({tag, "_s_res"}, 64'(s_res), rs);
    chk({tag, "_d_res"}, d_res, rd);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_ready"}, 64'({s_ready, d_ready}), 64'b11);
      chk({tag, "_hold_res"}, 64'(s_res), rs);
    end
    ack_fsm = 1'b1;
    if (mode == 2) begin
      beg_fsm = 1'b1;
      scramble();
    end
    @(posedge clk); #1;
    ack_fsm = 1'b0;
    beg_fsm = 1'b0;
    chk_idle({tag, "_ack"});
    chk({tag, "_res_kept"}, 64'(s_res), rs);
    chk({tag, "_flags_kept"}, 64'({s_ovf, s_unf, d_ovf, d_unf}), 64'({os, us, od, ud}));
    if (mode != 0) begin
      @(posedge clk); #1;
      chk_idle({tag, "_no_restart"});
    end
  endtask

  initial begin
    rst = 1'b1; beg_fsm = 1'b0; ack_fsm = 1'b0;
    sign_i = 1'b0; zero_flag_i = 1'b0;
    s_exp = '0; s_sgf = '0; d_exp = '0; d_sgf = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_s_res", 64'(s_res), 64'd0);
    chk("reset_d_res", d_res, 64'd0);
    chk("reset_flags", 64'({s_ovf, s_unf, d_ovf, d_unf}), 64'd0);
    rst = 1'b0;

    op("normal", 1'b0, 1'b0, 9'h080, 23'h0, 12'h3FF, 52'h0, 0, 0);
    op("ovf_s", 1'b1, 1'b0, 9'h0FF, 23'h12345, 12'h7FF, 52'h0, 0, 0);
    op("ovf_carry", 1'b0, 1'b0, 9'h1F0, 23'h7FFFFF, 12'h7FE, 52'hABCDE, 0, 0);
    op("unf", 1'b1, 1'b0, 9'h000, 23'h1, 12'h000, 52'h5, 0, 0);
    op("zero", 1'b1, 1'b1, 9'h000, 23'h1, 12'h7FF, 52'h5, 0, 0);
    op("hold10", 1'b0, 1'b0, 9'h0FE, 23'h7FFFFF, 12'h001, 52'h1, 10, 0);
    op("beg_in_check", 1'b1, 1'b0, 9'h001, 23'h55555, 12'h400, 52'h123, 0, 1);
    op("beg_ack_done", 1'b0, 1'b0, 9'h07F, 23'h2AAAAA, 12'h3FE, 52'hFFFFF, 1, 2);

    // Reset while the operation sits in FORMAT.
    @(posedge clk); #1;
    sign_i = 1'b1; zero_flag_i = 1'b0; s_exp = 9'h0FF; d_exp = 12'h7FF;
    beg_fsm = 1'b1;
    @(posedge clk); #1;
    beg_fsm = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle("rst_mid");
    chk("rst_mid_res", 64'(s_res) | d_res, 64'd0);
    chk("rst_mid_flags", 64'({s_ovf, s_unf, d_ovf, d_unf}), 64'd0);
    op("after_rst", 1'b0, 1'b0, 9'h080, 23'h1, 12'h3FF, 52'h1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      op($sformatf("rnd%0d", n), 1'($urandom), ($urandom_range(0, 7) == 0),
         9'(pick_exp(9)), 23'($urandom), 12'(pick_exp(12)), {20'($urandom), 32'($urandom)},
         $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_format_ctrl.md
# fpu_format_ctrl

Sequencer for the final formatting phase of the FP add/sub unit. It captures sign, biased exponent (with carry bit) and significand from the normalization phase on a start pulse. It classifies the exponent as overflow, underflow or in-range, then assembles the IEEE-754 result: infinity on overflow, signed zero on underflow or exact zero, packed value otherwise. It delivers the result through a ready/ack handshake to the FPU interface.

## Interface
- EW, 9: exponent width including carry bit; 9 = single, 12 = double
- SW, 23: stored significand width; 23 = single, 52 = double
- W, 32: result width; always 1 + (EW-1) + SW
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- beg_fsm  in  1  start; sampled only in IDLE
- ack_fsm  in  1  consumer acknowledge; sampled only in DONE
- sign_i  in  1  result sign
- exp_i  in  EW  biased exponent from normalization, MSB = carry
- sgf_i  in  SW  significand without hidden bit
- zero_flag_i  in  1  result is exactly zero
- busy  out  1  high in CHECK, FORMAT, DONE
- ready  out  1  high in DONE only
- final_result  out  W  formatted IEEE-754 word
- overflow_flag  out  1  registered overflow classification
- underflow_flag  out  1  registered underflow classification

## Operation
- Limits: U_LIMIT = {1'b0, (EW-2) ones, 1'b0}, which is 0x0FE for EW=9 and 0x7FE for EW=12. L_LIMIT = 1.
- Classification priority: zero_flag > overflow (exp > U_LIMIT, unsigned) > underflow (exp < L_LIMIT) > normal.
- Zero flag: both flags 0.
- Result by class:
  - Zero: {sign, 0...}.
  - Overflow: {sign, (EW-1) ones, SW zeros}.
  - Underflow: {sign, 0...}.
  - Normal: {sign, exp[EW-2:0], sgf}.
- FSM:
  - IDLE: beg_fsm=1 → CHECK; load sign/exp/sgf/zero registers.
  - CHECK: register overflow_flag/underflow_flag → FORMAT (unconditional).
  - FORMAT: register final_result → DONE (unconditional).
  - DONE: ack_fsm=1 → IDLE; otherwise stay.
- beg_fsm outside IDLE is ignored, and input registers do not change.
- ack_fsm outside DONE is ignored.
- beg_fsm and ack_fsm both high in DONE: return to IDLE; beg is not honored, and the requester must reassert.
- Inputs need only be valid in the cycle beg_fsm is sampled in IDLE.
- final_result and flags hold their values after ack until overwritten by the next operation's CHECK/FORMAT.

## Timing
- Reset: state IDLE; busy=0, ready=0, final_result=0, overflow_flag=0, underflow_flag=0; all capture registers 0.
- rst wins over every other input. Asserted mid-operation (any state), the next edge yields the reset values and the operation is discarded.
- Latency: beg sampled at edge N. busy high after N; flags valid after N+1; final_result valid and ready=1 after N+2.
- ready stays high until the edge sampling ack_fsm=1; busy and ready are low after that edge.
- Minimum issue interval: 4 cycles (beg, CHECK, FORMAT, ack same cycle as ready, then beg in IDLE).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package fpu_format_pkg holds:
  - the state enum (IDLE, CHECK, FORMAT, DONE; 2-bit encoding 0..3);
  - constant functions u_limit(EW) and l_limit(EW);
  - the single/double parameter sets (EW/SW/W).
- Sub-module exp_range_check (parameter EW): purely combinational, exp → overflow/underflow per the limits above. The controller registers its outputs in CHECK.
- Top holds the FSM, capture registers and result mux; 150-250 lines expected.

## Test plan
- Normal single, sign=0, exp=9'h080, sgf=0, beg one cycle → ready after 3rd edge, final_result=32'h40000000, flags 0/0; ack → busy=0, ready=0 next cycle.
- Overflow: exp=9'h0FF, sign=1 → final_result=32'hFF800000, overflow_flag=1. Also exp=9'h1F0 → 32'h7F800000 with sign=0.
- Underflow vs zero:
  - exp=9'h000, zero_flag=0, sign=1 → 32'h80000000, underflow_flag=1.
  - Same inputs with zero_flag=1 → 32'h80000000, both flags 0.
- Double build (EW=12, SW=52): exp=12'h7FF → overflow, result 64'h7FF0000000000000. exp=12'h3FF, sgf=0 → 64'h3FF0000000000000.
- Handshake:
  - Hold ack low 10 cycles → ready stays 1 and the result is stable.
  - beg pulsed during CHECK with new inputs → ignored, the first result is delivered.
  - beg and ack together in DONE → IDLE, no new operation starts.
- Reset mid-op: rst in FORMAT → next edge all outputs 0, state IDLE. A new beg then completes normally in 3 cycles.
